// File: rtl/fir_pkg.sv
// Shared FIR widths and sample/product types.
package fir_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned COE_WIDTH  = 16;
  localparam int unsigned OUT_WIDTH  = 16;
  localparam int unsigned PROD_WIDTH = DATA_WIDTH + COE_WIDTH;

  typedef logic signed [OUT_WIDTH-1:0]  sample_t;
  typedef logic signed [PROD_WIDTH-1:0] product_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head-of-queue output.
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_after_pop;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] head_d;
  logic             push_ok;
  logic             pop_ok;

  // Qualify push/pop and work out the next head so it can be registered.
  always_comb begin
    pop_ok          = pop && !empty_q;
    push_ok         = push && (!full_q || pop_ok);
    rd_next         = rd_ptr + AW'(pop_ok);
    count_after_pop = count_q - CW'(pop_ok);
    count_d         = count_after_pop + CW'(push_ok);
    head_d          = (count_after_pop == '0) ? wdata : mem[rd_next];
  end

  // Storage array; no reset needed, occupancy tracks validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy flags and head register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      head_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      head_q  <= head_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign head  = head_q;

endmodule

// File: rtl/fir_out_decim.sv
// FIR output stage: round, saturate, decimate and buffer the product stream.
module fir_out_decim #(
  parameter int unsigned IN_WIDTH    = fir_pkg::PROD_WIDTH,
  parameter int unsigned OUT_WIDTH   = fir_pkg::OUT_WIDTH,
  parameter int unsigned SHIFT       = 15,
  parameter int unsigned DECIM_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [IN_WIDTH-1:0]    data_i,
  input  logic [DECIM_WIDTH-1:0] decim_i,
  output logic [OUT_WIDTH-1:0]   data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [CNT_WIDTH-1:0]   drop_cnt_o,
  output logic [CNT_WIDTH-1:0]   sat_cnt_o
);

  localparam logic signed [IN_WIDTH:0] SAT_MAX =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [IN_WIDTH:0] SAT_MIN =
    {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [OUT_WIDTH-1:0]   OUT_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]   OUT_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
  localparam logic [DECIM_WIDTH-1:0] ONE     = DECIM_WIDTH'(1);

  logic signed [IN_WIDTH:0] data_ext;
  logic signed [IN_WIDTH:0] shifted;
  logic [OUT_WIDTH-1:0]     sat_data;
  logic                     clip;

  logic [DECIM_WIDTH-1:0]   phase_q;
  logic [DECIM_WIDTH-1:0]   phase_d;
  logic [DECIM_WIDTH-1:0]   factor_q;
  logic [DECIM_WIDTH-1:0]   factor_d;
  logic [DECIM_WIDTH-1:0]   factor_eff;
  logic [DECIM_WIDTH-1:0]   factor_use;
  logic                     keep;

  logic                     s1_keep;
  logic [OUT_WIDTH-1:0]     s1_data;
  logic                     s1_clip;

  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  logic [OUT_WIDTH-1:0]     fifo_head;

  logic [CNT_WIDTH-1:0]     drop_cnt_q;
  logic [CNT_WIDTH-1:0]     sat_cnt_q;

  assign data_ext = {data_i[IN_WIDTH-1], data_i};

  // Round half up with one guard bit so the add cannot overflow.
  if (SHIFT > 0) begin : g_round
    localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1) << (SHIFT - 1);
    logic signed [IN_WIDTH:0] rnd_sum;
    assign rnd_sum = data_ext + HALF;
    assign shifted = rnd_sum >>> SHIFT;
  end else begin : g_noround
    assign shifted = data_ext;
  end

  // Clamp to the output sample range and flag clipping.
  always_comb begin
    sat_data = shifted[OUT_WIDTH-1:0];
    clip     = 1'b0;
    if (shifted > SAT_MAX) begin
      sat_data = OUT_MAX;
      clip     = 1'b1;
    end else if (shifted < SAT_MIN) begin
      sat_data = OUT_MIN;
      clip     = 1'b1;
    end
  end

  // Decimation phase: keep at phase 0, latch a new factor only there.
  always_comb begin
    factor_eff = (decim_i == '0) ? ONE : decim_i;
    factor_use = (phase_q == '0) ? factor_eff : factor_q;
    keep       = en_i && (phase_q == '0);
    phase_d    = phase_q;
    factor_d   = factor_q;
    if (en_i) begin
      if (phase_q == '0) begin
        factor_d = factor_eff;
      end
      phase_d = (phase_q == factor_use - ONE) ? '0 : phase_q + ONE;
    end
  end

  // Decimator state and stage-1 pipeline register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= '0;
      factor_q <= ONE;
      s1_keep  <= 1'b0;
      s1_data  <= '0;
      s1_clip  <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      factor_q <= factor_d;
      s1_keep  <= keep;
      s1_data  <= sat_data;
      s1_clip  <= clip;
    end
  end

  assign fifo_pop = !fifo_empty && ready_i;

  // Stage 2: output buffer.
  sync_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (s1_keep),
    .wdata (s1_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Saturating drop and clip counters, counted as samples reach the buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
      sat_cnt_q  <= '0;
    end else begin
      if (s1_keep && fifo_full && !fifo_pop && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
      end
      if (s1_keep && s1_clip && (sat_cnt_q != '1)) begin
        sat_cnt_q <= sat_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  assign valid_o    = !fifo_empty;
  assign data_o     = fifo_head;
  assign drop_cnt_o = drop_cnt_q;
  assign sat_cnt_o  = sat_cnt_q;

endmodule

// File: tb/tb_fir_out_decim.sv
// Bench for fir_out_decim: directed scenarios plus random traffic against a queue model.
module tb_fir_out_decim;

  localparam int unsigned IN_WIDTH    = 32;
  localparam int unsigned OUT_WIDTH   = 16;
  localparam int unsigned SHIFT       = 15;
  localparam int unsigned DECIM_WIDTH = 8;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned CNT_WIDTH   = 16;

  localparam longint OUT_HI  = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam longint OUT_LO  = -(longint'(1) <<< (OUT_WIDTH - 1));
  localparam longint CNT_MAX = (longint'(1) <<< CNT_WIDTH) - 1;
  localparam int     ONE_LSB = 32768;

  logic                   clk_i;
  logic                   rst_i;
  logic                   en_i;
  logic [IN_WIDTH-1:0]    data_i;
  logic [DECIM_WIDTH-1:0] decim_i;
  logic [OUT_WIDTH-1:0]   data_o;
  logic                   valid_o;
  logic                   ready_i;
  logic [CNT_WIDTH-1:0]   drop_cnt_o;
  logic [CNT_WIDTH-1:0]   sat_cnt_o;

  fir_out_decim #(
    .IN_WIDTH    (IN_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT       (SHIFT),
    .DECIM_WIDTH (DECIM_WIDTH),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .data_i     (data_i),
    .decim_i    (decim_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .drop_cnt_o (drop_cnt_o),
    .sat_cnt_o  (sat_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks;
  int n_errors;

  // Reference model: sample queue, one-stage delay slot, countdown to next kept sample.
  int     mq[$];
  bit     m_s1_keep;
  int     m_s1_val;
  bit     m_s1_clip;
  int     m_remaining;
  longint m_drop;
  longint m_sat;
  int     got[$];
  int     exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint expv);
    n_checks++;
    if (obs != expv) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void ref_round(input int x, output int y, output bit clipped);
    longint v;
    v = (longint'(x) + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    clipped = 1'b0;
    if (v > OUT_HI) begin
      v = OUT_HI;
      clipped = 1'b1;
    end else if (v < OUT_LO) begin
      v = OUT_LO;
      clipped = 1'b1;
    end
    y = int'(v);
  endfunction

  task automatic model_step(input bit en, input int d, input int dec, input bit rdy, input bit rs);
    int  y;
    bit  c;
    if (rs) begin
      mq.delete();
      m_s1_keep   = 1'b0;
      m_remaining = 0;
      m_drop      = 0;
      m_sat       = 0;
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (m_s1_keep) begin
        if (m_s1_clip && m_sat < CNT_MAX) m_sat++;
        if (mq.size() < FIFO_DEPTH) mq.push_back(m_s1_val);
        else if (m_drop < CNT_MAX) m_drop++;
      end
      m_s1_keep = en && (m_remaining == 0);
      if (en) begin
        ref_round(d, y, c);
        m_s1_val  = y;
        m_s1_clip = c;
        if (m_remaining == 0) m_remaining = ((dec == 0) ? 1 : dec) - 1;
        else m_remaining--;
      end
    end
  endtask

  task automatic step(input bit en, input int d, input int dec, input bit rdy, input bit rs);
    en_i    = en;
    data_i  = IN_WIDTH'(d);
    decim_i = DECIM_WIDTH'(dec);
    ready_i = rdy;
    rst_i   = rs;
    if (valid_o && rdy && !rs) got.push_back(int'($signed(data_o)));
    model_step(en, d, dec, rdy, rs);
    @(posedge clk_i);
    #1;
    chk("valid", longint'(valid_o), longint'(mq.size() > 0));
    if (mq.size() > 0) chk("data", longint'($signed(data_o)), longint'(mq[0]));
    chk("drop_cnt", longint'(drop_cnt_o), m_drop);
    chk("sat_cnt", longint'(sat_cnt_o), m_sat);
  endtask

  task automatic idle(input int dec, input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, dec, rdy, 1'b0);
  endtask

  task automatic check_got(input string tag);
    chk({tag, "_count"}, longint'(got.size()), longint'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < got.size()) chk(tag, longint'(got[i]), longint'(exp_q[i]));
    end
    got.delete();
  endtask

  initial begin
    int hold;
    int r;
    clk_i       = 1'b0;
    n_checks    = 0;
    n_errors    = 0;
    m_s1_keep   = 1'b0;
    m_s1_val    = 0;
    m_s1_clip   = 1'b0;
    m_remaining = 0;
    m_drop      = 0;
    m_sat       = 0;
    en_i        = 1'b0;
    data_i      = '0;
    decim_i     = '0;
    ready_i     = 1'b0;
    rst_i       = 1'b1;

    // Reset state
    step(1'b0, 0, 1, 1'b1, 1'b1);
    step(1'b0, 0, 1, 1'b1, 1'b1);
    chk("rst_valid", longint'(valid_o), 0);
    chk("rst_data", longint'($signed(data_o)), 0);
    got.delete();

    // Rounding with latency check
    step(1'b1, 16384, 1, 1'b1, 1'b0);
    chk("lat_n1_valid", longint'(valid_o), 0);
    step(1'b1, 16383, 1, 1'b1, 1'b0);
    chk("lat_n2_valid", longint'(valid_o), 1);
    chk("lat_n2_data", longint'($signed(data_o)), 1);
    step(1'b1, -16384, 1, 1'b1, 1'b0);
    step(1'b1, -16385, 1, 1'b1, 1'b0);
    idle(1, 1'b1, 4);
    exp_q = '{1, 0, 0, -1};
    check_got("round");
    chk("round_sat", longint'(sat_cnt_o), 0);

    // Saturation
    step(1'b1, int'(32'h7FFF_FFFF), 1, 1'b1, 1'b0);
    step(1'b1, int'(32'h8000_0000), 1, 1'b1, 1'b0);
    idle(1, 1'b1, 4);
    exp_q = '{32767, -32768};
    check_got("saturate");
    chk("saturate_cnt", longint'(sat_cnt_o), 2);

    // Decimation by 4
    for (int k = 0; k < 12; k++) step(1'b1, k * ONE_LSB, 4, 1'b1, 1'b0);
    idle(4, 1'b1, 4);
    exp_q = '{0, 4, 8};
    check_got("decim4");

    // Factor change mid-stream applies after the next kept sample
    step(1'b1, 20 * ONE_LSB, 4, 1'b1, 1'b0);
    for (int k = 21; k < 30; k++) step(1'b1, k * ONE_LSB, 2, 1'b1, 1'b0);
    idle(2, 1'b1, 4);
    exp_q = '{20, 24, 26, 28};
    check_got("decim_change");

    // Factor 0 behaves as 1
    for (int k = 40; k < 43; k++) step(1'b1, k * ONE_LSB, 0, 1'b1, 1'b0);
    idle(0, 1'b1, 4);
    exp_q = '{40, 41, 42};
    check_got("decim0");

    // Backpressure: four buffered, two dropped, head stable while stalled
    for (int k = 1; k < 7; k++) step(1'b1, k * ONE_LSB, 1, 1'b0, 1'b0);
    idle(1, 1'b0, 2);
    chk("bp_drop", longint'(drop_cnt_o), 2);
    chk("bp_head", longint'($signed(data_o)), 1);
    hold = int'($signed(data_o));
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b0, 1);
      chk("bp_hold", longint'($signed(data_o)), longint'(hold));
    end
    idle(1, 1'b1, 6);
    exp_q = '{1, 2, 3, 4};
    check_got("bp_drain");

    // Full buffer with push and pop in the same cycle
    for (int k = 10; k < 14; k++) step(1'b1, k * ONE_LSB, 1, 1'b0, 1'b0);
    idle(1, 1'b0, 1);
    step(1'b1, 14 * ONE_LSB, 1, 1'b0, 1'b0);
    step(1'b0, 0, 1, 1'b1, 1'b0);
    chk("fullpop_drop", longint'(drop_cnt_o), 2);
    idle(1, 1'b1, 6);
    exp_q = '{10, 11, 12, 13, 14};
    check_got("fullpop");

    // Reset mid-stream with three buffered entries and phase != 0
    for (int k = 0; k < 8; k++) step(1'b1, (50 + k) * ONE_LSB, 3, 1'b0, 1'b0);
    idle(3, 1'b0, 2);
    chk("pre_rst_valid", longint'(valid_o), 1);
    step(1'b0, 0, 3, 1'b0, 1'b1);
    chk("mid_rst_valid", longint'(valid_o), 0);
    chk("mid_rst_drop", longint'(drop_cnt_o), 0);
    chk("mid_rst_sat", longint'(sat_cnt_o), 0);
    got.delete();
    step(1'b1, 60 * ONE_LSB, 3, 1'b1, 1'b0);
    idle(3, 1'b1, 4);
    exp_q = '{60};
    check_got("post_rst");

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 3))
        0:       r = int'($urandom);
        1:       r = int'($urandom_range(0, 2097152)) - 1048576;
        2:       r = 1073709056 + int'($urandom_range(0, 65536)) - 32768;
        default: r = -1073741824 + int'($urandom_range(0, 65536)) - 32768;
      endcase
      step(($urandom_range(0, 3) != 0), r, int'($urandom_range(0, 5)),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 255) == 0));
    end
    got.delete();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fir_out_decim.md
# fir_out_decim

Output stage placed directly downstream of `fir_filter`. It takes the full-precision signed FIR product stream, rounds it, saturates it back to sample width and decimates it by a run-time factor. The result is presented on a valid/ready interface through a small buffer. Samples that cannot be buffered are dropped and counted; saturation events are also counted.

## Interface
- `IN_WIDTH`, 32: width of the signed FIR output (`DATA_WIDTH + COE_WIDTH`).
- `OUT_WIDTH`, 16: width of the signed output sample.
- `SHIFT`, 15: arithmetic right shift applied before saturation, 0..IN_WIDTH-OUT_WIDTH.
- `DECIM_WIDTH`, 8: width of the decimation-factor port.
- `FIFO_DEPTH`, 4: output buffer entries, power of two, ≥2.
- `CNT_WIDTH`, 16: width of the status counters.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `en_i` in 1: input sample valid, same strobe that drives the FIR `en_i`.
- `data_i` in IN_WIDTH: signed FIR output.
- `decim_i` in DECIM_WIDTH: decimation factor; 0 is treated as 1.
- `data_o` out OUT_WIDTH: signed output sample.
- `valid_o` out 1: `data_o` is valid.
- `ready_i` in 1: sink accepts the sample (transfer when `valid_o && ready_i`).
- `drop_cnt_o` out CNT_WIDTH: count of kept samples lost because the buffer was full.
- `sat_cnt_o` out CNT_WIDTH: count of kept samples that were clipped.

## Operation
- Input accepted only on cycles with `en_i` = 1. There is no input backpressure.
- Rounding: when SHIFT > 0, add `1 << (SHIFT-1)` in IN_WIDTH+1 bits, then apply an arithmetic shift right by SHIFT. This is round-half-up. When SHIFT = 0, no add is performed.
- Saturation: clamp the shifted value to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Flag the sample as clipped if the clamp changed its value.
- Decimation: a phase counter advances once per accepted sample.
  - A sample is kept when phase = 0.
  - The phase wraps at factor-1.
  - `decim_i` is latched only when phase = 0, so a factor change takes effect at the next kept-sample boundary.
  - The first accepted sample after reset is kept.
- Buffer: a FIFO of FIFO_DEPTH entries.
  - A kept sample is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the sample is dropped and `drop_cnt_o` is incremented.
- `sat_cnt_o` increments only for clipped samples that are kept. This applies whether or not the sample is subsequently dropped.
- Both counters saturate at all-ones and do not wrap.
- `data_o` holds steady while `valid_o && !ready_i`.

## Timing
- Reset values:
  - `valid_o`, `data_o`, `drop_cnt_o`, `sat_cnt_o`: 0.
  - Phase counter: 0; latched factor: 1.
  - FIFO: empty.
- Reset mid-operation: FIFO contents are discarded and the counters are cleared. The first `en_i` after `rst_i` deasserts is kept.
- Pipeline:
  - Stage 1 registers the rounded, saturated value together with the keep and clip flags.
  - Stage 2 writes the FIFO.
  - A kept sample with `en_i` at cycle N appears on `valid_o`/`data_o` at cycle N+2 if the FIFO was empty.
- A pop at cycle N shows the next entry at N+1. There are no bubbles at full throughput, and `en_i` may be high every cycle.
- Simultaneous push and pop on an empty FIFO: the pushed sample is presented at N+2 as above. The FIFO output is not bypassed combinationally.

## Structure
- Shared package `fir_pkg`: default widths (`DATA_WIDTH`, `COE_WIDTH`, `OUT_WIDTH`), plus a typedef for the signed sample and the signed product.
- One sub-module: `sync_fifo`, with parameters WIDTH and DEPTH. Its ports are push, pop, full, empty and a registered head output. Rounding, saturation and the decimator stay in the top module.

## Test plan
- Rounding, SHIFT=15, decim 1, `ready_i`=1. Inputs 16384, 16383, -16384, -16385 → outputs 1, 0, 0, -1. Each appears 2 cycles after its `en_i`. `sat_cnt_o`=0.
- Saturation. Inputs 0x7FFF_FFFF and 0x8000_0000 → outputs 32767 and -32768. `sat_cnt_o`=2.
- Decimation, decim 4. Inputs k·32768 for k=0..11, `en_i` every cycle → outputs 0, 4, 8. Change `decim_i` to 2 mid-stream → the new factor applies only after the next kept sample. `decim_i`=0 behaves as 1.
- Backpressure. `ready_i`=0, decim 1, six inputs → four buffered, `drop_cnt_o`=2. Raise `ready_i` → the first four values are emitted in order, and `data_o` stays stable while stalled.
- Full plus pop. With the FIFO full, push and pop in the same cycle → no drop, and the order is preserved.
- Reset mid-stream. Assert `rst_i` with three entries buffered and phase ≠ 0 → next cycle `valid_o`=0 and both counters are 0. The first subsequent input is kept.
